// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: store sizes and store-buffer states.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: replicates the datum across lanes, builds byte enables
// and flags misaligned or illegal-size stores.
module store_lane_fmt
  import mips_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  always_comb begin
    wdata      = data;
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_store_align.sv
// MEM-stage store path: formats SB/SH/SW requests and queues them in a two-entry
// output/skid buffer towards data memory; misaligned stores are trapped, not written.
module mips_store_align
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("mips_store_align supports only DEPTH == 2");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d, skid_addr_q, skid_addr_d;
  lane_t             out_q, out_d, skid_q, skid_d;
  logic              misalign_q;
  logic [ADDR_W-1:0] misalign_addr_q;

  lane_t             fmt;
  logic              fmt_mis;
  logic [ADDR_W-1:0] new_addr;
  logic              accept, accept_ok, hs;

  store_lane_fmt u_fmt (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .data       (req_wdata),
    .wdata      (fmt.wdata),
    .be         (fmt.be),
    .misaligned (fmt_mis)
  );

  // Both handshake outputs depend on registered state only.
  assign req_ready = (state_q != FULL);
  assign mem_valid = (state_q == ONE) || (state_q == FULL);

  assign new_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign accept    = req_valid && req_ready;
  assign accept_ok = accept && !fmt_mis;
  assign hs        = mem_valid && mem_ready;

  always_comb begin
    state_d     = state_q;
    out_addr_d  = out_addr_q;
    out_d       = out_q;
    skid_addr_d = skid_addr_q;
    skid_d      = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_ok) begin
          state_d    = ONE;
          out_addr_d = new_addr;
          out_d      = fmt;
        end
      end
      ONE: begin
        if (hs && accept_ok) begin
          out_addr_d = new_addr;
          out_d      = fmt;
        end else if (hs) begin
          state_d = EMPTY;
        end else if (accept_ok) begin
          state_d     = FULL;
          skid_addr_d = new_addr;
          skid_d      = fmt;
        end
      end
      FULL: begin
        if (hs) begin
          state_d    = ONE;
          out_addr_d = skid_addr_q;
          out_d      = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= EMPTY;
      out_addr_q      <= '0;
      out_q           <= '0;
      skid_addr_q     <= '0;
      skid_q          <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      out_addr_q  <= out_addr_d;
      out_q       <= out_d;
      skid_addr_q <= skid_addr_d;
      skid_q      <= skid_d;
      misalign_q  <= accept && fmt_mis;
      if (accept && fmt_mis) misalign_addr_q <= req_addr;
    end
  end

  assign mem_addr      = out_addr_q;
  assign mem_wdata     = out_q.wdata;
  assign mem_be        = out_q.be;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_mips_store_align.sv
// Self-checking bench for mips_store_align: directed scenarios plus randomized traffic
// against a queue-based model of the store buffer.
module tb_mips_store_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];
  logic        exp_mis;
  logic [31:0] exp_mis_addr;

  always #5 clk = ~clk;

  mips_store_align #(.ADDR_W(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  function automatic bit ref_trap(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic st_t ref_fmt(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s);
    st_t r;
    r.addr = a - (a % 4);
    if (s == 2'd0) begin
      r.wdata = (d % 256) * 32'h0101_0101;
      r.be    = 4'(1 << (a % 4));
    end else if (s == 2'd1) begin
      r.wdata = (d % 65536) * 32'h0001_0001;
      r.be    = (a % 4 >= 2) ? 4'd12 : 4'd3;
    end else begin
      r.wdata = d;
      r.be    = 4'd15;
    end
    return r;
  endfunction

  // Advance the model by the inputs present now, then move to the next falling edge.
  task automatic tick();
    if (rst) begin
      q.delete();
      exp_mis      = 1'b0;
      exp_mis_addr = '0;
    end else begin
      bit rdy;
      rdy = (q.size() < 2);
      if (q.size() > 0 && mem_ready) void'(q.pop_front());
      exp_mis = 1'b0;
      if (req_valid && rdy) begin
        if (ref_trap(req_addr, req_size)) begin
          exp_mis      = 1'b1;
          exp_mis_addr = req_addr;
        end else begin
          q.push_back(ref_fmt(req_addr, req_wdata, req_size));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    tick(); tick();
    rst = 1'b0;
    n_vec += 4;
    if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", mem_valid); end
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      n_err++; $display("FAIL reset_payload got %h/%h/%b want 0", mem_addr, mem_wdata, mem_be);
    end
    if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_mis got %0b/%h want 0/0", misalign, misalign_addr);
    end
  endtask

  task automatic test_sb();
    mem_ready = 1'b1;
    set_req(1'b1, 32'h1003, 32'hAABBCCDD, 2'd0);
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec += 2;
    if (!(mem_valid === 1'b1 && mem_addr === 32'h1000 && mem_be === 4'b1000 &&
          mem_wdata === 32'hDDDDDDDD)) begin
      n_err++;
      $display("FAIL sb got v=%0b a=%h be=%b d=%h want 1/00001000/1000/dddddddd",
               mem_valid, mem_addr, mem_be, mem_wdata);
    end
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready got %0b want 1", req_ready); end
    tick();
  endtask

  task automatic test_sh_sw();
    mem_ready = 1'b1;
    set_req(1'b1, 32'h2002, 32'h12345678, 2'd1);
    tick();
    set_req(1'b1, 32'h2004, 32'h12345678, 2'd2);
    n_vec++;
    if (!(mem_addr === 32'h2000 && mem_be === 4'b1100 && mem_wdata === 32'h56785678)) begin
      n_err++;
      $display("FAIL sh got a=%h be=%b d=%h want 00002000/1100/56785678", mem_addr, mem_be, mem_wdata);
    end
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec++;
    if (!(mem_valid === 1'b1 && mem_addr === 32'h2004 && mem_be === 4'b1111 &&
          mem_wdata === 32'h12345678)) begin
      n_err++;
      $display("FAIL sw got v=%0b a=%h be=%b d=%h want 1/00002004/1111/12345678",
               mem_valid, mem_addr, mem_be, mem_wdata);
    end
    tick();
    n_vec++;
    if (mem_valid !== 1'b0) begin n_err++; $display("FAIL sw_drain got %0b want 0", mem_valid); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    set_req(1'b1, 32'h5000, 32'hA0A0A0A0, 2'd2); tick();
    set_req(1'b1, 32'h5004, 32'hB1B1B1B1, 2'd2); tick();
    set_req(1'b1, 32'h5008, 32'hC2C2C2C2, 2'd2);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (!(req_ready === 1'b0 && mem_valid === 1'b1 && mem_addr === 32'h5000 &&
            mem_wdata === 32'hA0A0A0A0 && mem_be === 4'hF)) begin
        n_err++;
        $display("FAIL stall[%0d] got r=%0b v=%0b a=%h d=%h want 0/1/00005000/a0a0a0a0",
                 i, req_ready, mem_valid, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    n_vec++;
    if (!(req_ready === 1'b1 && mem_addr === 32'h5004 && mem_wdata === 32'hB1B1B1B1)) begin
      n_err++;
      $display("FAIL drain_b got r=%0b a=%h d=%h want 1/00005004/b1b1b1b1", req_ready, mem_addr, mem_wdata);
    end
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec++;
    if (!(mem_valid === 1'b1 && mem_addr === 32'h5008 && mem_wdata === 32'hC2C2C2C2)) begin
      n_err++;
      $display("FAIL drain_c got v=%0b a=%h d=%h want 1/00005008/c2c2c2c2", mem_valid, mem_addr, mem_wdata);
    end
    tick();
    n_vec++;
    if (mem_valid !== 1'b0) begin n_err++; $display("FAIL drain_end got %0b want 0", mem_valid); end
  endtask

  task automatic test_misalign();
    mem_ready = 1'b1;
    set_req(1'b1, 32'h3001, 32'h11223344, 2'd2); tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec++;
    if (!(misalign === 1'b1 && misalign_addr === 32'h3001 && mem_valid === 1'b0)) begin
      n_err++;
      $display("FAIL trap got m=%0b ma=%h v=%0b want 1/00003001/0", misalign, misalign_addr, mem_valid);
    end
    set_req(1'b1, 32'h3001, 32'h00000055, 2'd0); tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec++;
    if (!(misalign === 1'b0 && misalign_addr === 32'h3001 && mem_valid === 1'b1 &&
          mem_addr === 32'h3000 && mem_be === 4'b0010 && mem_wdata === 32'h55555555)) begin
      n_err++;
      $display("FAIL trap_after got m=%0b ma=%h v=%0b a=%h be=%b d=%h want 0/3001/1/3000/0010/55555555",
               misalign, misalign_addr, mem_valid, mem_addr, mem_be, mem_wdata);
    end
    tick();
  endtask

  task automatic test_illegal();
    mem_ready = 1'b0;
    set_req(1'b1, 32'h4000, 32'h0000AAAA, 2'd2); tick();
    set_req(1'b1, 32'h4008, 32'hDEADBEEF, 2'd3); tick();
    set_req(1'b1, 32'h4004, 32'h0000BBBB, 2'd2);
    n_vec++;
    if (!(misalign === 1'b1 && misalign_addr === 32'h4008 && req_ready === 1'b1)) begin
      n_err++;
      $display("FAIL illegal got m=%0b ma=%h r=%0b want 1/00004008/1", misalign, misalign_addr, req_ready);
    end
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    mem_ready = 1'b1;
    n_vec++;
    if (!(misalign === 1'b0 && mem_addr === 32'h4000 && mem_wdata === 32'h0000AAAA)) begin
      n_err++; $display("FAIL illegal_first got m=%0b a=%h want 0/00004000", misalign, mem_addr);
    end
    tick();
    n_vec++;
    if (!(mem_valid === 1'b1 && mem_addr === 32'h4004 && mem_wdata === 32'h0000BBBB)) begin
      n_err++; $display("FAIL illegal_second got v=%0b a=%h want 1/00004004", mem_valid, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_full();
    mem_ready = 1'b0;
    set_req(1'b1, 32'h6000, 32'h1, 2'd2); tick();
    set_req(1'b1, 32'h6004, 32'h2, 2'd2); tick();
    set_req(1'b0, 32'h0, 32'h0, 2'd0);
    n_vec++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b want 0", req_ready); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++;
    if (!(mem_valid === 1'b0 && req_ready === 1'b1 && mem_addr === 32'h0 && mem_be === 4'h0)) begin
      n_err++;
      $display("FAIL rst_full got v=%0b r=%0b a=%h be=%b want 0/1/0/0", mem_valid, req_ready, mem_addr, mem_be);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_ghost[%0d] got %0b want 0", i, mem_valid); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      set_req(1'($urandom_range(0, 1)), 32'h7000 + $urandom_range(0, 63), $urandom,
              2'($urandom_range(0, 3)));
      tick();
      n_vec++;
      if (req_ready !== (q.size() < 2) || mem_valid !== (q.size() > 0)) begin
        n_err++;
        $display("FAIL rnd_hs[%0d] got r=%0b v=%0b want %0b/%0b", i, req_ready, mem_valid,
                 q.size() < 2, q.size() > 0);
      end
      n_vec++;
      if (misalign !== exp_mis || misalign_addr !== exp_mis_addr) begin
        n_err++;
        $display("FAIL rnd_mis[%0d] got %0b/%h want %0b/%h", i, misalign, misalign_addr,
                 exp_mis, exp_mis_addr);
      end
      if (q.size() > 0) begin
        n_vec++;
        if (mem_addr !== q[0].addr || mem_wdata !== q[0].wdata || mem_be !== q[0].be) begin
          n_err++;
          $display("FAIL rnd_data[%0d] got %h/%h/%b want %h/%h/%b", i, mem_addr, mem_wdata,
                   mem_be, q[0].addr, q[0].wdata, q[0].be);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sb();
    test_sh_sw();
    test_back_to_back();
    test_misalign();
    test_illegal();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
